// File: rtl/ofdm_ctrl_pkg.sv
// Shared constants and types for the OFDM configuration bank: register-slot
// indices, error-bit positions, FSM states, qam_mode codes and FFT config fields.
package ofdm_ctrl_pkg;

   // Register-snapshot slot indices
   localparam int SLOT_QAM      = 0;
   localparam int SLOT_PIL_LOC  = 1;
   localparam int SLOT_PIL_VAL  = 2;
   localparam int SLOT_CP_LEN   = 3;
   localparam int SLOT_FFT_CFG  = 4;
   localparam int SLOT_FRM_LEN  = 5;
   localparam int SLOT_PRE_SYM  = 6;
   localparam int SLOT_PRE_CFG  = 7;
   localparam int NUM_SLOTS     = 8;

   // Error-vector bit positions
   localparam int ERR_DATA      = 0;
   localparam int ERR_CYCLIC    = 1;
   localparam int ERR_FFT       = 2;
   localparam int ERR_PILOT     = 3;
   localparam int ERR_PREAMBLE  = 4;
   localparam int ERR_QAM       = 5;
   localparam int ERR_OVERRUN   = 6;
   localparam int ERR_BITS      = 7;

   // FFT config register fields
   localparam int FFT_LOG2_LSB  = 0;
   localparam int FFT_LOG2_MSB  = 4;
   localparam int FFT_INV_BIT   = 5;
   localparam int FFT_CP_EN_BIT = 6;

   // qam_mode output codes; 0 means no configuration applied yet
   localparam logic [2:0] QAM_NONE  = 3'd0;
   localparam logic [2:0] QAM_BPSK  = 3'd1;
   localparam logic [2:0] QAM_QPSK  = 3'd2;
   localparam logic [2:0] QAM_16    = 3'd3;
   localparam logic [2:0] QAM_64    = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_CHECK,
      ST_WAIT_FRAME
   } state_t;

   // Map a validated QAM select (0..3) onto its qam_mode code
   function automatic logic [2:0] qam_code(input logic [1:0] sel);
      logic [2:0] code;
      case (sel)
         2'd0:    code = QAM_BPSK;
         2'd1:    code = QAM_QPSK;
         2'd2:    code = QAM_16;
         default: code = QAM_64;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/ofdm_cfg_checker.sv
// Combinational validation of a shadow register snapshot against the FFT size.
// Produces the per-field error vector; the overrun bit is never set here.
module ofdm_cfg_checker
   import ofdm_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int MAX_FFT_LOG2 = 13,
   parameter int MIN_FFT_LOG2 = 3
) (
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] cfg,
   output logic [ERR_BITS-1:0]             err
);

   localparam logic [4:0] MIN_L = 5'(MIN_FFT_LOG2);
   localparam logic [4:0] MAX_L = 5'(MAX_FFT_LOG2);

   logic [DATA_WIDTH-1:0] qam_sel;
   logic [DATA_WIDTH-1:0] pil_loc;
   logic [DATA_WIDTH-1:0] cp_len;
   logic [DATA_WIDTH-1:0] fft_cfg;
   logic [DATA_WIDTH-1:0] frame_len;
   logic [DATA_WIDTH-1:0] pre_cfg;
   logic [4:0]            log2n;
   logic [4:0]            n_log2;
   logic                  fft_bad;
   logic                  unused_bits;

   assign qam_sel   = cfg[SLOT_QAM*DATA_WIDTH     +: DATA_WIDTH];
   assign pil_loc   = cfg[SLOT_PIL_LOC*DATA_WIDTH +: DATA_WIDTH];
   assign cp_len    = cfg[SLOT_CP_LEN*DATA_WIDTH  +: DATA_WIDTH];
   assign fft_cfg   = cfg[SLOT_FFT_CFG*DATA_WIDTH +: DATA_WIDTH];
   assign frame_len = cfg[SLOT_FRM_LEN*DATA_WIDTH +: DATA_WIDTH];
   assign pre_cfg   = cfg[SLOT_PRE_CFG*DATA_WIDTH +: DATA_WIDTH];

   // Fields that carry data but need no validation
   assign unused_bits = ^{cfg[SLOT_PIL_VAL*DATA_WIDTH +: DATA_WIDTH],
                          cfg[SLOT_PRE_SYM*DATA_WIDTH +: DATA_WIDTH],
                          fft_cfg[DATA_WIDTH-1:FFT_CP_EN_BIT+1],
                          fft_cfg[FFT_INV_BIT], pre_cfg[15:0], qam_sel[1:0]};

   // Field checks; a bad FFT size falls back to the largest N for the
   // pilot and CP range checks so those report independently
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      err     = '0;
      log2n   = fft_cfg[FFT_LOG2_MSB:FFT_LOG2_LSB];
      fft_bad = (log2n < MIN_L) || (log2n > MAX_L);
      n_log2  = fft_bad ? MAX_L : log2n;

      err[ERR_QAM]      = (qam_sel[DATA_WIDTH-1:2] != '0);
      err[ERR_FFT]      = fft_bad;
      err[ERR_PILOT]    = ((pil_loc >> n_log2) != '0);
      err[ERR_CYCLIC]   = fft_cfg[FFT_CP_EN_BIT] && ((cp_len >> n_log2) != '0);
      err[ERR_DATA]     = (frame_len == '0);
      err[ERR_PREAMBLE] = (pre_cfg[DATA_WIDTH-1:16] != '0);
   end

endmodule

// File: rtl/ofdm_cfg_bank.sv
// OFDM configuration controller: captures a register snapshot into a shadow
// bank, validates it, and applies it atomically to the active set (at the next
// frame boundary when SYNC_TO_FRAME=1). Keeps sticky per-field error flags.
module ofdm_cfg_bank
   import ofdm_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_FFT_LOG2  = 13,
   parameter int MIN_FFT_LOG2  = 3,
   parameter int SYNC_TO_FRAME = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SLOTS*DATA_WIDTH-1:0] cfg_in,
   input  logic                            cfg_commit,
   input  logic                            frame_start,
   input  logic                            err_clr,
   output logic [2:0]                      qam_mode,
   output logic [MAX_FFT_LOG2-1:0]         pil_loc,
   output logic [DATA_WIDTH-1:0]           pil_val,
   output logic [4:0]                      fft_log2,
   output logic                            fft_inv,
   output logic                            cp_en,
   output logic [MAX_FFT_LOG2-1:0]         cp_len,
   output logic [DATA_WIDTH-1:0]           frame_len,
   output logic [DATA_WIDTH-1:0]           pre_sym,
   output logic [DATA_WIDTH-1:0]           pre_cfg,
   output logic [DATA_WIDTH-1:0]           error_reg,
   output logic                            busy,
   output logic                            cfg_applied,
   output logic                            cfg_rejected
);

   state_t                          state_q, state_d;
   logic [NUM_SLOTS*DATA_WIDTH-1:0] shadow_q;
   logic [ERR_BITS-1:0]             chk_err;
   logic [ERR_BITS-1:0]             err_q;
   logic [ERR_BITS-1:0]             err_sticky;
   logic [ERR_BITS-1:0]             set_bits;
   logic                            do_capture;
   logic                            do_apply;
   logic                            do_reject;

   ofdm_cfg_checker #(
      .DATA_WIDTH   (DATA_WIDTH),
      .MAX_FFT_LOG2 (MAX_FFT_LOG2),
      .MIN_FFT_LOG2 (MIN_FFT_LOG2)
   ) u_checker (
      .cfg (shadow_q),
      .err (chk_err)
   );

   assign busy      = (state_q != ST_IDLE);
   assign error_reg = {{(DATA_WIDTH-ERR_BITS){1'b0}}, err_sticky};

   // Next-state and per-cycle action decode
   always_comb begin
      state_d    = state_q;
      do_capture = 1'b0;
      do_apply   = 1'b0;
      do_reject  = 1'b0;
      set_bits   = '0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_commit) begin
               do_capture = 1'b1;
               state_d    = ST_CAPTURE;
            end
         end
         ST_CAPTURE: state_d = ST_CHECK;
         ST_CHECK: begin
            if (err_q != '0) begin
               do_reject = 1'b1;
               set_bits  = err_q;
               state_d   = ST_IDLE;
            end else if (SYNC_TO_FRAME != 0) begin
               state_d   = ST_WAIT_FRAME;
            end else begin
               do_apply  = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WAIT_FRAME: begin
            if (frame_start) begin
               do_apply = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A commit while a transaction is in flight is dropped and flagged
      if (cfg_commit && state_q != ST_IDLE) set_bits[ERR_OVERRUN] = 1'b1;
   end

   // State register, shadow capture and registered check result
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         state_q  <= ST_IDLE;
         // NOTE: the shadow bank is reset so an aborted transaction leaves nothing behind.
         shadow_q <= '0;
         err_q    <= '0;
      end else begin
         state_q <= state_d;
         if (do_capture)           shadow_q <= cfg_in;
         if (state_q == ST_CAPTURE) err_q    <= chk_err;
      end
   end

   // Sticky error flags; fresh errors win over a coincident clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_sticky <= '0;
      end else if (set_bits != '0) begin
         err_sticky <= err_clr ? set_bits : (err_sticky | set_bits);
      end else if (err_clr) begin
         err_sticky <= '0;
      end
   end

   // Result strobes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_applied  <= 1'b0;
         cfg_rejected <= 1'b0;
      end else begin
         cfg_applied  <= do_apply;
         cfg_rejected <= do_reject;
      end
   end

   // Active set: every field updates together from the validated shadow bank
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qam_mode  <= QAM_NONE;
         pil_loc   <= '0;
         pil_val   <= '0;
         fft_log2  <= '0;
         fft_inv   <= 1'b0;
         cp_en     <= 1'b0;
         cp_len    <= '0;
         frame_len <= '0;
         pre_sym   <= '0;
         pre_cfg   <= '0;
      end else if (do_apply) begin
         qam_mode  <= qam_code(shadow_q[SLOT_QAM*DATA_WIDTH +: 2]);
         pil_loc   <= shadow_q[SLOT_PIL_LOC*DATA_WIDTH +: MAX_FFT_LOG2];
         pil_val   <= shadow_q[SLOT_PIL_VAL*DATA_WIDTH +: DATA_WIDTH];
         fft_log2  <= shadow_q[SLOT_FFT_CFG*DATA_WIDTH + FFT_LOG2_LSB +: 5];
         fft_inv   <= shadow_q[SLOT_FFT_CFG*DATA_WIDTH + FFT_INV_BIT];
         cp_en     <= shadow_q[SLOT_FFT_CFG*DATA_WIDTH + FFT_CP_EN_BIT];
         cp_len    <= shadow_q[SLOT_CP_LEN*DATA_WIDTH +: MAX_FFT_LOG2];
         frame_len <= shadow_q[SLOT_FRM_LEN*DATA_WIDTH +: DATA_WIDTH];
         pre_sym   <= shadow_q[SLOT_PRE_SYM*DATA_WIDTH +: DATA_WIDTH];
         pre_cfg   <= shadow_q[SLOT_PRE_CFG*DATA_WIDTH +: DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_ofdm_cfg_bank.sv
// Directed self-checking bench for ofdm_cfg_bank with SYNC_TO_FRAME=1.
module tb_ofdm_cfg_bank;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [255:0]  cfg_in = '0;
   logic          cfg_commit = 1'b0;
   logic          frame_start = 1'b0;
   logic          err_clr = 1'b0;
   logic [2:0]    qam_mode;
   logic [12:0]   pil_loc;
   logic [31:0]   pil_val;
   logic [4:0]    fft_log2;
   logic          fft_inv;
   logic          cp_en;
   logic [12:0]   cp_len;
   logic [31:0]   frame_len;
   logic [31:0]   pre_sym;
   logic [31:0]   pre_cfg;
   logic [31:0]   error_reg;
   logic          busy;
   logic          cfg_applied;
   logic          cfg_rejected;

   logic [31:0]   slot [8];
   int            tests = 0;
   int            failed = 0;

   ofdm_cfg_bank #(
      .DATA_WIDTH    (32),
      .MAX_FFT_LOG2  (13),
      .MIN_FFT_LOG2  (3),
      .SYNC_TO_FRAME (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_in       (cfg_in),
      .cfg_commit   (cfg_commit),
      .frame_start  (frame_start),
      .err_clr      (err_clr),
      .qam_mode     (qam_mode),
      .pil_loc      (pil_loc),
      .pil_val      (pil_val),
      .fft_log2     (fft_log2),
      .fft_inv      (fft_inv),
      .cp_en        (cp_en),
      .cp_len       (cp_len),
      .frame_len    (frame_len),
      .pre_sym      (pre_sym),
      .pre_cfg      (pre_cfg),
      .error_reg    (error_reg),
      .busy         (busy),
      .cfg_applied  (cfg_applied),
      .cfg_rejected (cfg_rejected)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg();
      cfg_in = {slot[7], slot[6], slot[5], slot[4], slot[3], slot[2], slot[1], slot[0]};
   endtask

   // Reference clean configuration: 16-QAM, N=1024, pilot 100, CP 64 enabled
   task automatic set_good();
      slot[0] = 32'd2;
      slot[1] = 32'd100;
      slot[2] = 32'hABCD_1234;
      slot[3] = 32'd64;
      slot[4] = 32'h0000_004A;
      slot[5] = 32'd14;
      slot[6] = 32'h0000_5A5A;
      slot[7] = 32'h0000_0003;
   endtask

   // One-cycle commit; returns 1 unit after the sampling edge T
   task automatic commit();
      load_cfg();
      cfg_commit = 1'b1;
      step();
      cfg_commit = 1'b0;
   endtask

   task automatic strobe_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic clear_errors();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask

   initial begin
      // ---- Reset state ----
      #2;
      check("rst_qam", 32'(qam_mode), 32'd0);
      check("rst_err", error_reg, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_applied", 32'(cfg_applied), 32'd0);
      check("rst_rejected", 32'(cfg_rejected), 32'd0);
      check("rst_fft", 32'(fft_log2), 32'd0);
      step();
      rst = 1'b1;
      step();

      // ---- Clean apply synchronised to frame_start ----
      set_good();
      commit();
      check("apply_busy_rise", 32'(busy), 32'd1);
      step();
      step();
      check("apply_wait_noapply", 32'(cfg_applied), 32'd0);
      check("apply_wait_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("apply_hold_qam", 32'(qam_mode), 32'd0);
      end
      strobe_frame();
      check("apply_pulse", 32'(cfg_applied), 32'd1);
      check("apply_busy_fall", 32'(busy), 32'd0);
      check("apply_qam", 32'(qam_mode), 32'd3);
      check("apply_fft", 32'(fft_log2), 32'd10);
      check("apply_cp_len", 32'(cp_len), 32'd64);
      check("apply_cp_en", 32'(cp_en), 32'd1);
      check("apply_inv", 32'(fft_inv), 32'd0);
      check("apply_pil_loc", 32'(pil_loc), 32'd100);
      check("apply_pil_val", pil_val, 32'hABCD_1234);
      check("apply_frame_len", frame_len, 32'd14);
      check("apply_pre_sym", pre_sym, 32'h0000_5A5A);
      check("apply_pre_cfg", pre_cfg, 32'h0000_0003);
      step();
      check("apply_pulse_one_cycle", 32'(cfg_applied), 32'd0);

      // ---- Reject: QAM select out of range ----
      set_good();
      slot[0] = 32'd5;
      slot[4] = 32'h0000_0008;
      commit();
      step();
      check("rej_qam_noearly", 32'(cfg_rejected), 32'd0);
      step();
      check("rej_qam_pulse", 32'(cfg_rejected), 32'd1);
      check("rej_qam_err", error_reg, 32'h20);
      check("rej_qam_busy", 32'(busy), 32'd0);
      check("rej_qam_hold_qam", 32'(qam_mode), 32'd3);
      check("rej_qam_hold_fft", 32'(fft_log2), 32'd10);
      step();
      check("rej_qam_pulse_end", 32'(cfg_rejected), 32'd0);
      clear_errors();
      check("clr_after_qam", error_reg, 32'd0);

      // ---- Reject: pilot at N ----
      set_good();
      slot[1] = 32'd1024;
      commit();
      step();
      step();
      check("rej_pilot_err", error_reg, 32'h08);
      check("rej_pilot_pulse", 32'(cfg_rejected), 32'd1);
      clear_errors();

      // ---- Reject: FFT size above max; pilot/CP judged against 8192 ----
      set_good();
      slot[4] = 32'h0000_004E;
      commit();
      step();
      step();
      check("rej_fft_err", error_reg, 32'h04);
      clear_errors();

      // ---- Overrun: second commit while waiting for the frame ----
      set_good();
      slot[0] = 32'd1;
      slot[1] = 32'd10;
      slot[3] = 32'd16;
      slot[4] = 32'h0000_0008;
      commit();
      step();
      step();
      slot[0] = 32'd3;
      slot[4] = 32'h0000_000C;
      commit();
      check("ovr_err", error_reg, 32'h40);
      check("ovr_busy", 32'(busy), 32'd1);
      step();
      strobe_frame();
      check("ovr_applied", 32'(cfg_applied), 32'd1);
      check("ovr_first_qam", 32'(qam_mode), 32'd2);
      check("ovr_first_fft", 32'(fft_log2), 32'd8);
      check("ovr_first_cp_en", 32'(cp_en), 32'd0);
      clear_errors();

      // ---- Early strobe in the CHECK->WAIT_FRAME cycle is ignored ----
      set_good();
      slot[0] = 32'd0;
      slot[4] = 32'h0000_002C;
      commit();
      step();
      strobe_frame();
      check("early_no_apply", 32'(cfg_applied), 32'd0);
      check("early_busy", 32'(busy), 32'd1);
      check("early_hold_qam", 32'(qam_mode), 32'd2);
      step();
      strobe_frame();
      check("early_next_apply", 32'(cfg_applied), 32'd1);
      check("early_qam", 32'(qam_mode), 32'd1);
      check("early_fft", 32'(fft_log2), 32'd12);
      check("early_inv", 32'(fft_inv), 32'd1);

      // ---- Sticky error clear ----
      set_good();
      slot[0] = 32'd4;
      slot[5] = 32'd0;
      commit();
      step();
      step();
      check("sticky_0x21", error_reg, 32'h21);
      step();
      check("sticky_hold", error_reg, 32'h21);
      clear_errors();
      check("sticky_cleared", error_reg, 32'd0);

      // ---- err_clr coinciding with fresh errors ----
      set_good();
      slot[0] = 32'd7;
      commit();
      step();
      step();
      check("coin_pre", error_reg, 32'h20);
      set_good();
      slot[5] = 32'd0;
      commit();
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("coin_new_wins", error_reg, 32'h01);

      // ---- Async reset while waiting for the frame ----
      set_good();
      commit();
      step();
      step();
      check("arst_pre_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #2;
      check("arst_qam", 32'(qam_mode), 32'd0);
      check("arst_fft", 32'(fft_log2), 32'd0);
      check("arst_pil_val", pil_val, 32'd0);
      check("arst_err", error_reg, 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      step();
      rst = 1'b1;
      step();
      strobe_frame();
      check("arst_no_apply", 32'(cfg_applied), 32'd0);
      check("arst_no_apply_qam", 32'(qam_mode), 32'd0);
      check("arst_idle", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
